// File: rtl/c6288_multiplier.sv
// Registered 16x16 unsigned array multiplier (c6288 pin naming).
// 256 partial-product ANDs reduced row by row with ripple-carry adders; product registered once.
module c6288_multiplier (
  input  logic clk,
  input  logic rst_n,
  input  logic N1,   input  logic N18,  input  logic N35,  input  logic N52,
  input  logic N69,  input  logic N86,  input  logic N103, input  logic N120,
  input  logic N137, input  logic N154, input  logic N171, input  logic N188,
  input  logic N205, input  logic N222, input  logic N239, input  logic N256,
  input  logic N273, input  logic N290, input  logic N307, input  logic N324,
  input  logic N341, input  logic N358, input  logic N375, input  logic N392,
  input  logic N409, input  logic N426, input  logic N443, input  logic N460,
  input  logic N477, input  logic N494, input  logic N511, input  logic N528,
  output logic N545,  output logic N1581, output logic N1901, output logic N2223,
  output logic N2548, output logic N2877, output logic N3211, output logic N3552,
  output logic N3895, output logic N4241, output logic N4591, output logic N4946,
  output logic N5308, output logic N5672, output logic N5971, output logic N6123,
  output logic N6150, output logic N6160, output logic N6170, output logic N6180,
  output logic N6190, output logic N6200, output logic N6210, output logic N6220,
  output logic N6230, output logic N6240, output logic N6250, output logic N6260,
  output logic N6270, output logic N6280, output logic N6287, output logic N6288
);

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [31:0] prod_comb;
  logic [31:0] prod_q;

  logic [15:0] row_sum;
  logic        row_cout;
  logic [15:0] row_in;
  logic [15:0] pp;
  logic [15:0] next_sum;
  logic        carry;

  assign op_a = {N256, N239, N222, N205, N188, N171, N154, N137,
                 N120, N103, N86,  N69,  N52,  N35,  N18,  N1};
  assign op_b = {N528, N511, N494, N477, N460, N443, N426, N409,
                 N392, N375, N358, N341, N324, N307, N290, N273};

  // Each row adds the next partial product to the previous row's sum shifted down one bit;
  // the bit shifted out is a finished product bit.
  always_comb begin
    prod_comb = '0;
    row_sum   = op_a & {16{op_b[0]}};
    row_cout  = 1'b0;
    row_in    = '0;
    pp        = '0;
    next_sum  = '0;
    carry     = 1'b0;
    for (int j = 1; j < 16; j++) begin
      prod_comb[j-1] = row_sum[0];
      row_in = {row_cout, row_sum[15:1]};
      pp     = op_a & {16{op_b[j]}};
      carry  = 1'b0;
      for (int i = 0; i < 16; i++) begin
        next_sum[i] = row_in[i] ^ pp[i] ^ carry;
        carry       = (row_in[i] & pp[i]) | (row_in[i] & carry) | (pp[i] & carry);
      end
      row_sum  = next_sum;
      row_cout = carry;
    end
    prod_comb[31:15] = {row_cout, row_sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else        prod_q <= prod_comb;
  end

  assign N545  = prod_q[0];   assign N1581 = prod_q[1];
  assign N1901 = prod_q[2];   assign N2223 = prod_q[3];
  assign N2548 = prod_q[4];   assign N2877 = prod_q[5];
  assign N3211 = prod_q[6];   assign N3552 = prod_q[7];
  assign N3895 = prod_q[8];   assign N4241 = prod_q[9];
  assign N4591 = prod_q[10];  assign N4946 = prod_q[11];
  assign N5308 = prod_q[12];  assign N5672 = prod_q[13];
  assign N5971 = prod_q[14];  assign N6123 = prod_q[15];
  assign N6150 = prod_q[16];  assign N6160 = prod_q[17];
  assign N6170 = prod_q[18];  assign N6180 = prod_q[19];
  assign N6190 = prod_q[20];  assign N6200 = prod_q[21];
  assign N6210 = prod_q[22];  assign N6220 = prod_q[23];
  assign N6230 = prod_q[24];  assign N6240 = prod_q[25];
  assign N6250 = prod_q[26];  assign N6260 = prod_q[27];
  assign N6270 = prod_q[28];  assign N6280 = prod_q[29];
  assign N6287 = prod_q[30];  assign N6288 = prod_q[31];

endmodule

// File: tb/tb_c6288_multiplier.sv
// Directed and random checks of the registered 16x16 multiplier.
module tb_c6288_multiplier;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  wire  [31:0] p;
  int          n_run;
  int          n_fail;

  c6288_multiplier dut (
    .clk(clk), .rst_n(rst_n),
    .N1(a[0]),    .N18(a[1]),   .N35(a[2]),   .N52(a[3]),
    .N69(a[4]),   .N86(a[5]),   .N103(a[6]),  .N120(a[7]),
    .N137(a[8]),  .N154(a[9]),  .N171(a[10]), .N188(a[11]),
    .N205(a[12]), .N222(a[13]), .N239(a[14]), .N256(a[15]),
    .N273(b[0]),  .N290(b[1]),  .N307(b[2]),  .N324(b[3]),
    .N341(b[4]),  .N358(b[5]),  .N375(b[6]),  .N392(b[7]),
    .N409(b[8]),  .N426(b[9]),  .N443(b[10]), .N460(b[11]),
    .N477(b[12]), .N494(b[13]), .N511(b[14]), .N528(b[15]),
    .N545(p[0]),   .N1581(p[1]),  .N1901(p[2]),  .N2223(p[3]),
    .N2548(p[4]),  .N2877(p[5]),  .N3211(p[6]),  .N3552(p[7]),
    .N3895(p[8]),  .N4241(p[9]),  .N4591(p[10]), .N4946(p[11]),
    .N5308(p[12]), .N5672(p[13]), .N5971(p[14]), .N6123(p[15]),
    .N6150(p[16]), .N6160(p[17]), .N6170(p[18]), .N6180(p[19]),
    .N6190(p[20]), .N6200(p[21]), .N6210(p[22]), .N6220(p[23]),
    .N6230(p[24]), .N6240(p[25]), .N6250(p[26]), .N6260(p[27]),
    .N6270(p[28]), .N6280(p[29]), .N6287(p[30]), .N6288(p[31])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive operands between edges, then sample just after the loading edge
  task automatic load(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    #1 rst_n = 1'b0;
    #1;
    n_run++;
    if (p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", p, 32'h0);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", p, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] va [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h1234, 16'h8000, 16'h00FF};
    logic [15:0] vb [6] = '{16'hFFFF, 16'hABCD, 16'hFFFF, 16'h5678, 16'h0002, 16'h00FF};
    logic [31:0] vp [6] = '{32'h00000000, 32'h0000ABCD, 32'hFFFE0001,
                            32'h06260060, 32'h00010000, 32'h0000FE01};
    for (int k = 0; k < 6; k++) begin
      load(va[k], vb[k]);
      n_run++;
      if (p !== vp[k]) begin
        n_fail++;
        $display("FAIL basic_%0d: %h*%h got %h want %h", k, va[k], vb[k], p, vp[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [5] = '{16'h0003, 16'h0100, 16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] vb [5] = '{16'h0005, 16'h0100, 16'h0002, 16'h8000, 16'h0001};
    logic [31:0] vp [5] = '{32'h0000000F, 32'h00010000, 32'h0001FFFE,
                            32'h40000000, 32'h0000FFFF};
    logic [31:0] prev;
    prev = p;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = va[k];
      b = vb[k];
      #1;
      n_run++;
      if (p !== prev) begin
        n_fail++;
        $display("FAIL b2b_early_%0d: got %h want %h", k, p, prev);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (p !== vp[k]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h want %h", k, p, vp[k]);
      end
      prev = vp[k];
    end
  endtask

  task automatic test_mid_cycle;
    load(16'h1234, 16'h5678);
    #2;
    a = 16'hFFFF;
    b = 16'hFFFF;
    #1;
    n_run++;
    if (p !== 32'h06260060) begin
      n_fail++;
      $display("FAIL mid_cycle_hold: got %h want %h", p, 32'h06260060);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (p !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL mid_cycle_next: got %h want %h", p, 32'hFFFE0001);
    end
  endtask

  task automatic test_reset_mid;
    load(16'hABCD, 16'h0010);
    n_run++;
    if (p !== 32'h000ABCD0) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want %h", p, 32'h000ABCD0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", p, 32'h0);
    end
    @(negedge clk);
    a = 16'h0007;
    b = 16'h0009;
    rst_n = 1'b1;
    #1;
    n_run++;
    if (p !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", p, 32'h0);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (p !== 32'h0000003F) begin
      n_fail++;
      $display("FAIL after_reset: got %h want %h", p, 32'h0000003F);
    end
  endtask

  task automatic test_random;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] want;
    int          bad;
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      load(ra, rb);
      want = 32'(ra) * 32'(rb);
      n_run++;
      if (p !== want) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random_%0d: %h*%h got %h want %h", k, ra, rb, p, want);
      end
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_mid_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
